fp16_norm_round: RTL and testbench
==================================

# fp16_norm_round

Sequential normalize-and-round stage for FP16 datapath results. It consumes the raw 2·(FRACW+1)-bit unsigned significand produced by the integer fused multiply-add stage, together with a sign and a working exponent. It shifts the significand to its normalized position one bit per cycle, rounds to nearest-even, and packs an IEEE-754 binary16 word. It sits directly downstream of the FMAD stage and upstream of the FPU result register.

## Interface
- `FRACW`, default `` `FP16_FRACW `` (10): stored fraction width.
- `EXPW`, default 5: exponent field width.
- `BIAS`, default 15: exponent bias.
- `INW`, default 2·(FRACW+1) = 22: width of the significand input.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE and DONE.
- `normIn`  in  INW  unsigned significand; value = normIn × 2^(expIn − BIAS − 2·FRACW).
- `expIn`  in  EXPW+2 (signed)  working biased exponent; may be ≤ 0 or ≥ 31.
- `signIn`  in  1  result sign.
- `normOut`  out  1+EXPW+FRACW  packed FP16 result `{sign, exp, frac}`; registered.
- `normDone`  out  1  result valid.
- `ovf`, `unf`, `inexact`  out  1 each  status flags; present only with `FP_NORM_FLAGS_EN` defined.

## Operation
- The FSM has four states: IDLE, SHIFT, ROUND, DONE.
- **IDLE / DONE + start:**
  - Capture `normIn` into a 22-bit mantissa register `m`.
  - Capture `expIn` into exponent register `e`, and `signIn` into the sign register.
  - Clear the sticky register `s`.
  - Go to SHIFT.
  - In DONE, `start` also drops `normDone` on the same edge.
- **SHIFT:** one action per cycle, evaluated in priority order:
  1. `m == 0`: go to ROUND (zero result).
  2. `m[INW-1]` set, or `e < 1`: shift right by one, `s |= m[0]`, `e += 1`.
  3. `m[2·FRACW]` clear and `e > 1`: shift left by one, `e −= 1`.
  4. Otherwise: go to ROUND with no change.
- **ROUND:**
  - Kept bits: `K = m[2·FRACW:FRACW]`.
  - Guard bit: `G = m[FRACW−1]`. Sticky: `S = |m[FRACW−2:0] | s`.
  - Round up when `G & (S | K[0])`.
  - If rounding carries K to 2^(FRACW+1): set K = 2^FRACW and increment `e`.
  - Exponent field = `e` if `K[FRACW]` is set, else 0 (subnormal or zero).
  - If `e ≥ 2^EXPW − 1`: `normOut = {sign, 5'h1F, 0}` (infinity).
  - Zero result: `normOut = {sign, 0, 0}` (signed zero preserved).
  - Register `normOut` and go to DONE.
- **DONE:**
  - `normDone = 1`; `normOut` is held.
  - State is held until `start` is seen.
- `start` is ignored while in SHIFT or ROUND.
- NaN is never produced; inputs are always finite.

## Timing
- Start sampled at edge E0.
  - For a shift count k: edges E1..Ek perform shifts.
  - E(k+1) enters ROUND.
  - E(k+2) registers `normOut` and asserts `normDone`.
  - Latency is therefore k+2 cycles; an already-normalized input takes 2.
- k is bounded by the leading-zero count plus the right shifts needed to reach `e = 1`. The worst case is INW+2^EXPW cycles.
- Reset values: state IDLE, `normOut = 0`, `normDone = 0`, flags 0, and `m`/`e`/`s` all 0.
- Reset asserted mid-operation aborts immediately: IDLE, outputs 0, and no partial result is visible.
- Back-to-back operation: `start` held high in DONE restarts on every DONE visit. `normDone` is high for exactly one cycle per result in that case.

## Configuration
- Macro `FP_NORM_FLAGS_EN`.
- **Defined:** `ovf`, `unf`, and `inexact` ports exist. They are registered alongside `normOut` at the ROUND→DONE edge and cleared on every `start` capture.
  - `ovf`: infinity produced.
  - `unf`: exponent field 0 and the result is inexact.
  - `inexact`: `G | S`.
- **Undefined:** the ports and their logic are absent; all other behaviour is identical.

## Test plan
- Normalized input: `normIn=0x100000`, `expIn=15`, `signIn=0` → `normOut=0x3C00` (1.0), `normDone` 2 cycles after start.
- Carry-out position: `normIn=0x300000`, `expIn=15` → 1 right shift, `normOut=0x4200` (3.0), latency 3.
- Deep normalization: `normIn=0x000400`, `expIn=15` → 10 left shifts, `normOut=0x1400`, latency 12.
- Round-to-nearest-even:
  - `normIn=0x100600`, `expIn=15` → `0x3C02` (tie rounds up to even).
  - `normIn=0x100200` → `0x3C00` (tie stays even).
  - `normIn=0x100201` → `0x3C01`.
- Overflow and zero:
  - `normIn=0x3FFFFF`, `expIn=30` → `0x7C00`, with `ovf=1`/`inexact=1` when flags are enabled.
  - `normIn=0`, `signIn=1` → `0x8000` in 2 cycles.
- Subnormal and reset:
  - `normIn=0x100000`, `expIn=−1` → 2 right shifts, `normOut=0x0100`.
  - Reset asserted in SHIFT → outputs 0 and IDLE next edge; a following start completes correctly.

Source files
------------

// File: rtl/fp16_norm_round_if.sv
// Handshake/data bundle between the FMAD stage, fp16_norm_round and the FPU result register.
// Status flag signals exist only when FP_NORM_FLAGS_EN is defined.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

interface fp16_norm_round_if #(
   parameter int FRACW = `FP16_FRACW,
   parameter int EXPW  = 5,
   parameter int INW   = 2 * (FRACW + 1)
);
   logic                     start;
   logic [INW-1:0]           normIn;
   logic signed [EXPW+1:0]   expIn;
   logic                     signIn;
   logic [EXPW+FRACW:0]      normOut;
   logic                     normDone;
`ifdef FP_NORM_FLAGS_EN
   logic                     ovf;
   logic                     unf;
   logic                     inexact;
`endif

   modport master (
      output start, normIn, expIn, signIn,
      input  normOut, normDone
`ifdef FP_NORM_FLAGS_EN
      , input ovf, unf, inexact
`endif
   );

   modport slave (
      input  start, normIn, expIn, signIn,
      output normOut, normDone
`ifdef FP_NORM_FLAGS_EN
      , output ovf, unf, inexact
`endif
   );
endinterface

// File: rtl/fp16_norm_round.sv
// Sequential normalize (one bit per cycle) + round-to-nearest-even + FP16 pack.
// Optional ovf/unf/inexact status outputs are built when FP_NORM_FLAGS_EN is defined.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif

module fp16_norm_round #(
   parameter int FRACW = `FP16_FRACW,
   parameter int EXPW  = 5,
   parameter int BIAS  = 15,
   parameter int INW   = 2 * (FRACW + 1)
) (
   input logic clock,
   input logic reset,
   fp16_norm_round_if.slave bus
);
   // state | meaning
   // IDLE  | waiting for start
   // SHIFT | moving significand toward bit 2*FRACW, one bit per cycle
   // ROUND | round-to-nearest-even and pack
   // DONE  | result valid and held until next start
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // One spare exponent bit so right shifts and the rounding carry cannot wrap.
   localparam int EW = EXPW + 3;
   localparam logic signed [EW-1:0] C_ONE  = EW'(1);
   localparam logic signed [EW-1:0] C_EMAX = EW'((1 << EXPW) - 1);

   if (BIAS <= 0) begin : g_bias_chk
      $error("fp16_norm_round: BIAS must be positive");
   end

   logic [1:0]              r_state;
   logic [INW-1:0]          r_m;
   logic signed [EW-1:0]    r_e;
   logic                    r_s;
   logic                    r_sign;
   logic [EXPW+FRACW:0]     r_out;
   logic                    r_done;

   logic [FRACW:0]          w_k;
   logic                    w_g;
   logic                    w_st;
   logic                    w_up;
   logic [FRACW+1:0]        w_ksum;
   logic [FRACW:0]          w_kr;
   logic signed [EW-1:0]    w_er;
   logic                    w_zero;
   logic                    w_inf;
   logic [EXPW+FRACW:0]     w_pack;

   always_comb begin
      w_k    = r_m[2*FRACW:FRACW];
      w_g    = r_m[FRACW-1];
      w_st   = (|r_m[FRACW-2:0]) | r_s;
      w_up   = w_g & (w_st | w_k[0]);
      w_ksum = {1'b0, w_k} + {{(FRACW+1){1'b0}}, w_up};
      w_kr   = w_ksum[FRACW:0];
      w_er   = r_e;
      if (w_ksum[FRACW+1]) begin
         w_kr = {1'b1, {FRACW{1'b0}}};
         w_er = r_e + C_ONE;
      end
      w_zero = (r_m == '0);
      w_inf  = !w_zero && (w_er >= C_EMAX);
      if (w_zero)
         w_pack = {r_sign, {(EXPW+FRACW){1'b0}}};
      else if (w_inf)
         w_pack = {r_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
      else
         w_pack = {r_sign, (w_kr[FRACW] ? w_er[EXPW-1:0] : {EXPW{1'b0}}), w_kr[FRACW-1:0]};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_e     <= '0;
         r_s     <= 1'b0;
         r_sign  <= 1'b0;
         r_out   <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_m     <= bus.normIn;
                  r_e     <= {bus.expIn[EXPW+1], bus.expIn};
                  r_sign  <= bus.signIn;
                  r_s     <= 1'b0;
                  r_done  <= 1'b0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (r_m == '0) begin
                  r_state <= S_ROUND;
               end else if (r_m[INW-1] || (r_e < C_ONE)) begin
                  r_m <= r_m >> 1;
                  r_s <= r_s | r_m[0];
                  r_e <= r_e + C_ONE;
               end else if (!r_m[2*FRACW] && (r_e > C_ONE)) begin
                  r_m <= r_m << 1;
                  r_e <= r_e - C_ONE;
               end else begin
                  r_state <= S_ROUND;
               end
            end
            default: begin
               r_out   <= w_pack;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
         endcase
      end
   end

   assign bus.normOut  = r_out;
   assign bus.normDone = r_done;

`ifdef FP_NORM_FLAGS_EN
   logic r_ovf;
   logic r_unf;
   logic r_inexact;
   logic w_inx;

   assign w_inx = w_g | w_st;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_inexact <= 1'b0;
      end else if ((r_state == S_IDLE || r_state == S_DONE) && bus.start) begin
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
         r_inexact <= 1'b0;
      end else if (r_state == S_ROUND) begin
         r_ovf     <= w_inf;
         r_unf     <= (w_pack[EXPW+FRACW-1:FRACW] == '0) && w_inx;
         r_inexact <= w_inx;
      end
   end

   assign bus.ovf     = r_ovf;
   assign bus.unf     = r_unf;
   assign bus.inexact = r_inexact;
`endif
endmodule

// File: tb/tb_fp16_norm_round.sv
// Scoreboard bench for fp16_norm_round: directed vectors push expected results,
// an independent monitor pops and compares on every new normDone.
module tb_fp16_norm_round;
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   fp16_norm_round_if #(.FRACW(10), .EXPW(5)) bus ();

   fp16_norm_round #(.FRACW(10), .EXPW(5), .BIAS(15)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] out;
      int          lat;
      logic [2:0]  flg;   // {ovf, unf, inexact}
      time         t0;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   prev_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         prev_done = 1'b0;
      end else begin
         if (bus.normDone && !prev_done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: actual=%0h required=none", bus.normOut);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_out"}, 32'(bus.normOut), 32'(e.out));
               chk({e.name, "_lat"}, 32'(($time - 5 - e.t0) / 10), 32'(e.lat));
`ifdef FP_NORM_FLAGS_EN
               chk({e.name, "_flags"}, 32'({bus.ovf, bus.unf, bus.inexact}), 32'(e.flg));
`endif
            end
         end
         prev_done = bus.normDone;
      end
   end

   task automatic issue(input logic [21:0] n, input logic signed [6:0] ex, input logic sg,
                        input logic [15:0] eo, input int lat, input logic [2:0] fl,
                        input string nm);
      exp_t e;
      @(negedge clock);
      bus.normIn = n;
      bus.expIn  = ex;
      bus.signIn = sg;
      bus.start  = 1'b1;
      @(posedge clock);
      e.out = eo; e.lat = lat; e.flg = fl; e.t0 = $time; e.name = nm;
      sb.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
   endtask

   task automatic wait_empty(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: actual=pending required=done", nm);
         sb.delete();
      end
   endtask

   task automatic run(input logic [21:0] n, input logic signed [6:0] ex, input logic sg,
                      input logic [15:0] eo, input int lat, input logic [2:0] fl,
                      input string nm);
      issue(n, ex, sg, eo, lat, fl, nm);
      wait_empty(nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   n;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.normIn = '0;
      bus.expIn  = '0;
      bus.signIn = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_out", 32'(bus.normOut), 32'h0);
      chk("rst_done", 32'(bus.normDone), 32'h0);
`ifdef FP_NORM_FLAGS_EN
      chk("rst_flags", 32'({bus.ovf, bus.unf, bus.inexact}), 32'h0);
`endif
      reset = 1'b0;
      @(negedge clock);

      run(22'h100000,  7'sd15, 1'b0, 16'h3C00,  2, 3'b000, "one");
      run(22'h300000,  7'sd15, 1'b0, 16'h4200,  3, 3'b000, "three");
      run(22'h300000,  7'sd15, 1'b1, 16'hC200,  3, 3'b000, "neg_three");
      run(22'h000400,  7'sd15, 1'b0, 16'h1400, 12, 3'b000, "deep");
      run(22'h100600,  7'sd15, 1'b0, 16'h3C02,  2, 3'b001, "tie_up");
      run(22'h100200,  7'sd15, 1'b0, 16'h3C00,  2, 3'b001, "tie_even");
      run(22'h100201,  7'sd15, 1'b0, 16'h3C01,  2, 3'b001, "above_half");
      run(22'h3FFFFF,  7'sd30, 1'b0, 16'h7C00,  3, 3'b101, "ovf_round");
      run(22'h100000,  7'sd31, 1'b0, 16'h7C00,  2, 3'b100, "ovf_exp31");
      run(22'h1FFC00,  7'sd30, 1'b0, 16'h7BFF,  2, 3'b000, "max_norm");
      run(22'h000000,  7'sd15, 1'b1, 16'h8000,  2, 3'b000, "neg_zero");
      run(22'h100000, -7'sd1,  1'b0, 16'h0100,  4, 3'b000, "subnorm");
      run(22'h100001, -7'sd1,  1'b0, 16'h0100,  4, 3'b011, "subnorm_inx");
      run(22'h100000, -7'sd20, 1'b0, 16'h0000, 23, 3'b011, "flush");

      // back-to-back: start held high through DONE
      @(negedge clock);
      bus.normIn = 22'h100000; bus.expIn = 7'sd15; bus.signIn = 1'b0; bus.start = 1'b1;
      @(posedge clock);
      e.out = 16'h3C00; e.lat = 2; e.flg = 3'b000; e.t0 = $time; e.name = "b2b_a";
      sb.push_back(e);
      n = 0;
      @(negedge clock);
      while (!bus.normDone && n < 50) begin
         @(negedge clock);
         n++;
      end
      bus.normIn = 22'h000400;
      @(posedge clock);
      e.out = 16'h1400; e.lat = 12; e.flg = 3'b000; e.t0 = $time; e.name = "b2b_b";
      sb.push_back(e);
      @(negedge clock);
      chk("b2b_done_pulse", 32'(bus.normDone), 32'h0);
      bus.start = 1'b0;
      wait_empty("b2b");

      // reset mid-SHIFT aborts with no visible result
      issue(22'h000400, 7'sd15, 1'b0, 16'h1400, 12, 3'b000, "aborted");
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("abort_out", 32'(bus.normOut), 32'h0);
      chk("abort_done", 32'(bus.normDone), 32'h0);
      sb.delete();
      @(negedge clock);
      chk("abort_hold_done", 32'(bus.normDone), 32'h0);
      reset = 1'b0;

      run(22'h100201, 7'sd15, 1'b1, 16'hBC01, 2, 3'b001, "after_reset");
      run(22'h300000, 7'sd15, 1'b0, 16'h4200, 3, 3'b000, "after_reset2");

      repeat (3) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
